mux4_rr_select_arbiter: RTL and testbench

- Round-robin arbiter that sits directly upstream of the team's 4:1 data mux.
- Four requesters compete for the mux output. The block registers a one-hot grant and drives the mux's 2-bit select.
- A hold limit stops any one requester from monopolising the mux while others are waiting.

---
 rtl/mux4_rr_select_arbiter.sv | 133 +++++++++++++
 tb/tb_mux4_rr_select_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_select_arbiter.sv
// Round-robin arbiter for a 4:1 data mux. It registers a one-hot grant and the matching
// 2-bit select, and a hold limit forces rotation when other requesters are waiting.
module mux4_rr_select_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] select,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_reg, state_next;
  logic [1:0]       last_reg, last_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       gnt_reg, gnt_next;
  logic [1:0]       sel_reg, sel_next;
  logic             valid_reg, valid_next;
  logic             preempt_reg, preempt_next;

  // The current owner is never a candidate, so one search serves release and rotation alike.
  logic [3:0] search_req;
  logic [1:0] search_base;
  logic [3:0] rot_req;
  logic [1:0] rot_idx [4];
  logic [1:0] win;
  logic       others_pending;
  logic       owner_req;

  assign search_req     = req & ~gnt_reg;
  assign search_base    = (state_reg == GRANT) ? sel_reg : last_reg;
  assign others_pending = |search_req;
  assign owner_req      = |(req & gnt_reg);

  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot_idx[gi] = search_base + 2'(gi + 1);
    assign rot_req[gi] = search_req[rot_idx[gi]];
  end

  always_comb begin
    win = '0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) win = rot_idx[k];
    end
  end

  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    cnt_next     = cnt_reg;
    gnt_next     = gnt_reg;
    sel_next     = sel_reg;
    valid_next   = valid_reg;
    preempt_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (others_pending) begin
          state_next = GRANT;
          gnt_next   = 4'b0001 << win;
          sel_next   = win;
          valid_next = 1'b1;
          cnt_next   = '0;
        end
      end
      GRANT: begin
        if (owner_req) begin
          if (cnt_reg < HOLD_LAST) begin
            cnt_next = cnt_reg + 1'b1;
          end else if (others_pending) begin
            last_next    = sel_reg;
            gnt_next     = 4'b0001 << win;
            sel_next     = win;
            cnt_next     = '0;
            preempt_next = 1'b1;
          end else begin
            // Nobody else waiting: restart the tenure without a visible break.
            cnt_next = '0;
          end
        end else begin
          last_next = sel_reg;
          cnt_next  = '0;
          if (others_pending) begin
            gnt_next = 4'b0001 << win;
            sel_next = win;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
            valid_next = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      last_reg    <= 2'd3;
      cnt_reg     <= '0;
      gnt_reg     <= '0;
      sel_reg     <= '0;
      valid_reg   <= 1'b0;
      preempt_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      cnt_reg     <= cnt_next;
      gnt_reg     <= gnt_next;
      sel_reg     <= sel_next;
      valid_reg   <= valid_next;
      preempt_reg <= preempt_next;
    end
  end

  assign gnt       = gnt_reg;
  assign select    = sel_reg;
  assign gnt_valid = valid_reg;
  assign preempt   = preempt_reg;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_reg));
  a_valid_or    : assert property (@(posedge clk) disable iff (!rst_n) valid_reg == |gnt_reg);
  a_sel_match   : assert property (@(posedge clk) disable iff (!rst_n)
                                   valid_reg |-> (gnt_reg == (4'b0001 << sel_reg)));

endmodule

// File: tb/tb_mux4_rr_select_arbiter.sv
// Scoreboard bench for mux4_rr_select_arbiter: a tenure-based reference model queues the
// expected registered outputs each cycle and a negedge monitor compares them.
module tb_mux4_rr_select_arbiter;

  localparam int HOLD_MAX = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] select;
  logic       gnt_valid;
  logic       preempt;

  int checks = 0;
  int failures = 0;
  int pops = 0;

  mux4_rr_select_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .select(select), .gnt_valid(gnt_valid), .preempt(preempt)
  );

  always #5 clk = ~clk;

  // Reference model: owner (-1 when idle), last released owner, cycles held in this tenure.
  int m_owner = -1;
  int m_last = 3;
  int m_held = 0;
  int m_sel = 0;
  logic [7:0] exp_q [$];

  function automatic int pick(int base, logic [3:0] mask);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
    m_sel   = 0;
    exp_q.delete();
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      logic [3:0] r;
      logic [3:0] others;
      logic [3:0] g;
      int w;
      logic pre;
      r = req;
      pre = 1'b0;
      if (m_owner < 0) begin
        w = pick(m_last, r);
        if (w >= 0) begin
          m_owner = w; m_held = 1; m_sel = w;
        end
      end else if (r[m_owner]) begin
        if (m_held < HOLD_MAX) begin
          m_held++;
        end else begin
          others = r;
          others[m_owner] = 1'b0;
          w = pick(m_owner, others);
          if (w >= 0) begin
            m_last = m_owner; m_owner = w; m_held = 1; m_sel = w; pre = 1'b1;
          end else begin
            m_held = 1;
          end
        end
      end else begin
        m_last = m_owner;
        w = pick(m_owner, r);
        if (w >= 0) begin
          m_owner = w; m_held = 1; m_sel = w;
        end else begin
          m_owner = -1;
        end
      end
      g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      exp_q.push_back({g, 2'(m_sel), (m_owner >= 0), pre});
    end
  end

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      logic [7:0] e;
      logic [7:0] a;
      e = exp_q.pop_front();
      a = {gnt, select, gnt_valid, preempt};
      pops++;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t req=%b: got gnt=%b sel=%0d valid=%b pre=%b, expected gnt=%b sel=%0d valid=%b pre=%b",
                 $time, req, a[7:4], a[3:2], a[1], a[0], e[7:4], e[3:2], e[1], e[0]);
      end
    end
  end

  task automatic check(string name, logic [7:0] actual, logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic set_req(logic [3:0] r, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req = r;
    end
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, then release with req_after applied.
  task automatic mid_reset(logic [3:0] req_after);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", {gnt, select, gnt_valid, preempt}, 8'h00);
    model_reset();
    req = req_after;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    repeat (3) @(negedge clk);
    check("reset_state", {gnt, select, gnt_valid, preempt}, 8'h00);
    #1;
    rst_n = 1'b1;

    set_req(4'b0000, 5);

    // Owners 0,1,2,3,0 each drop their request for one cycle.
    for (int k = 0; k < 5; k++) begin
      set_req(4'b1111, 2);
      set_req(4'b1111 & ~(4'b0001 << (k % 4)), 1);
    end
    set_req(4'b0000, 2);

    set_req(4'b0101, 18);
    set_req(4'b0000, 2);

    set_req(4'b0010, 12);
    set_req(4'b1001, 1);
    @(negedge clk);
    check("owner_drop_search", {gnt, select}, {4'b1000, 2'd3});

    set_req(4'b0000, 2);
    set_req(4'b0100, 3);
    mid_reset(4'b1100);
    @(negedge clk);
    check("post_reset_grant", {gnt, select, gnt_valid}, {4'b0100, 2'd2, 1'b1});

    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if (i < 200) r = r ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      else         r = r ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      set_req(r, 1);
      if (i == 250) mid_reset(r);
    end
    set_req(4'b0000, 3);

    checks++;
    if (pops < 400) begin
      failures++;
      $display("FAIL scoreboard_activity: got %0d compares, expected at least 400", pops);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
